// File: rtl/i_mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of the instruction-memory arbiter.
// The arbiter connects through the slave modport; requesters plus memory use master.
interface i_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);

    // Port 0: CPU fetch unit
    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_ack;
    logic [7:0]            p0_rdata;

    // Port 1: bracket-scan / debug-loader path
    logic                  p1_req;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic                  p1_ack;
    logic [7:0]            p1_rdata;

    // Shared single-port instruction memory
    logic                  m_req;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_ack;
    logic [7:0]            m_rdata;

    modport slave (
        input  p0_req,
        input  p0_addr,
        output p0_ack,
        output p0_rdata,
        input  p1_req,
        input  p1_addr,
        output p1_ack,
        output p1_rdata,
        output m_req,
        output m_addr,
        input  m_ack,
        input  m_rdata
    );

    modport master (
        output p0_req,
        output p0_addr,
        input  p0_ack,
        input  p0_rdata,
        output p1_req,
        output p1_addr,
        input  p1_ack,
        input  p1_rdata,
        input  m_req,
        input  m_addr,
        output m_ack,
        output m_rdata
    );

endinterface

// File: rtl/i_mem_arbiter.sv
// Two-port arbiter for the BF CPU instruction memory: one outstanding read at a time,
// with a forced one-cycle idle gap after every memory ack.
module i_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    i_mem_arbiter_if.slave   mem_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam bit RR_EN = (ROUND_ROBIN != 0);

    state_t                state_q;
    state_t                state_d;
    logic                  grant_q;
    logic                  grant_d;
    logic                  last_q;
    logic                  last_d;
    logic                  m_req_q;
    logic                  m_req_d;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [ADDR_WIDTH-1:0] m_addr_d;

    logic                  any_req_s;
    logic                  winner_s;
    logic                  busy_ack_s;

    assign any_req_s  = mem_if.p0_req | mem_if.p1_req;
    assign busy_ack_s = (state_q == ST_BUSY) & mem_if.m_ack;

    // Winner selection; on a tie, round-robin hands the grant to the port that did not win last
    always_comb begin
        winner_s = 1'b0;
        if (mem_if.p0_req && mem_if.p1_req) begin
            if (RR_EN) begin
                winner_s = ~last_q;
            end else begin
                winner_s = 1'b0;
            end
        end else if (mem_if.p1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state and registered-output logic of the transaction sequencer
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        m_req_d  = m_req_q;
        m_addr_d = m_addr_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (any_req_s) begin
                    state_d  = ST_BUSY;
                    grant_d  = winner_s;
                    last_d   = winner_s;
                    m_req_d  = 1'b1;
                    m_addr_d = winner_s ? mem_if.p1_addr : mem_if.p0_addr;
                end else begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                end
            end
            ST_BUSY: begin
                // The request is finished even if the requester has dropped it; the GAP
                // cycle lets the memory's registered ready clear before the next grant.
                if (mem_if.m_ack) begin
                    state_d = ST_GAP;
                    m_req_d = 1'b0;
                end else begin
                    state_d = ST_BUSY;
                    m_req_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // Sequencer state register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            m_req_q  <= 1'b0;
            m_addr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            m_req_q  <= m_req_d;
            m_addr_q <= m_addr_d;
        end
    end

    assign mem_if.m_req  = m_req_q;
    assign mem_if.m_addr = m_addr_q;

    // Acks pass m_ack through with no added latency, gated so a dropped request gets none
    assign mem_if.p0_ack   = busy_ack_s & ~grant_q & mem_if.p0_req;
    assign mem_if.p1_ack   = busy_ack_s &  grant_q & mem_if.p1_req;
    assign mem_if.p0_rdata = mem_if.m_rdata;
    assign mem_if.p1_rdata = mem_if.m_rdata;

endmodule

// File: tb/tb_i_mem_arbiter.sv
// Directed bench for i_mem_arbiter: a round-robin and a fixed-priority instance,
// each with a 1-cycle registered-read memory model.
module tb_i_mem_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    i_mem_arbiter_if #(.ADDR_WIDTH(16)) bus0 ();
    i_mem_arbiter_if #(.ADDR_WIDTH(16)) bus1 ();

    i_mem_arbiter #(.ADDR_WIDTH(16), .ROUND_ROBIN(1)) dut_rr (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus0)
    );

    i_mem_arbiter #(.ADDR_WIDTH(16), .ROUND_ROBIN(0)) dut_fp (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a == 16'h0010) return 8'h2B;
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'hA5;
    endfunction

    // Memory models: ready flag is registered and clears the cycle after it is seen
    logic       m0_ack_q;
    logic [7:0] m0_rdata_q;
    logic       m1_ack_q;
    logic [7:0] m1_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_ack_q   <= 1'b0;
            m0_rdata_q <= 8'h00;
            m1_ack_q   <= 1'b0;
            m1_rdata_q <= 8'h00;
        end else begin
            m0_ack_q   <= bus0.m_req & ~m0_ack_q;
            m0_rdata_q <= mem_val(bus0.m_addr);
            m1_ack_q   <= bus1.m_req & ~m1_ack_q;
            m1_rdata_q <= mem_val(bus1.m_addr);
        end
    end

    assign bus0.m_ack   = m0_ack_q;
    assign bus0.m_rdata = m0_rdata_q;
    assign bus1.m_ack   = m1_ack_q;
    assign bus1.m_rdata = m1_rdata_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus0.p0_req = 1'b0; bus0.p0_addr = 16'h0000; bus0.p1_req = 1'b0; bus0.p1_addr = 16'h0000;
        bus1.p0_req = 1'b0; bus1.p0_addr = 16'h0000; bus1.p1_req = 1'b0; bus1.p1_addr = 16'h0000;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL reset_mreq0: got %0b exp 0", bus0.m_req); end
        n_chk++; if (bus0.m_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_maddr0: got %h exp 0000", bus0.m_addr); end
        n_chk++; if (bus1.m_req !== 1'b0) begin n_fail++; $display("FAIL reset_mreq1: got %0b exp 0", bus1.m_req); end
        n_chk++; if ({bus0.p0_ack, bus0.p1_ack, bus1.p0_ack, bus1.p1_ack} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_acks: got %b exp 0000", {bus0.p0_ack, bus0.p1_ack, bus1.p0_ack, bus1.p1_ack}); end
    endtask

    task automatic test_single_fetch;
        do_reset();
        bus0.p0_req = 1'b1; bus0.p0_addr = 16'h0010;
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL single_c0_mreq: got %0b exp 0", bus0.m_req); end
        tick();
        n_chk++; if (bus0.m_req !== 1'b1) begin n_fail++; $display("FAIL single_c1_mreq: got %0b exp 1", bus0.m_req); end
        n_chk++; if (bus0.m_addr !== 16'h0010) begin n_fail++; $display("FAIL single_c1_maddr: got %h exp 0010", bus0.m_addr); end
        n_chk++; if (bus0.p0_ack !== 1'b0) begin n_fail++; $display("FAIL single_c1_ack: got %0b exp 0", bus0.p0_ack); end
        tick();
        n_chk++; if (bus0.p0_ack !== 1'b1) begin n_fail++; $display("FAIL single_c2_ack: got %0b exp 1", bus0.p0_ack); end
        n_chk++; if (bus0.p0_rdata !== 8'h2B) begin n_fail++; $display("FAIL single_c2_rdata: got %h exp 2b", bus0.p0_rdata); end
        n_chk++; if (bus0.p1_ack !== 1'b0) begin n_fail++; $display("FAIL single_c2_p1ack: got %0b exp 0", bus0.p1_ack); end
        tick();
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL single_c3_mreq: got %0b exp 0", bus0.m_req); end
        n_chk++; if (bus0.p0_ack !== 1'b0) begin n_fail++; $display("FAIL single_c3_ack: got %0b exp 0", bus0.p0_ack); end
        bus0.p0_req = 1'b0;
        tick();
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL single_c4_idle: got %0b exp 0", bus0.m_req); end
    endtask

    task automatic test_rr_contention;
        logic e0, e1, er;
        logic [15:0] ea;
        do_reset();
        bus0.p0_req = 1'b1; bus0.p0_addr = 16'h0000;
        bus0.p1_req = 1'b1; bus0.p1_addr = 16'h0100;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            e0 = (c == 2) || (c == 8);
            e1 = (c == 5) || (c == 11);
            er = (c % 3) != 0;
            ea = (((c / 3) % 2) == 0) ? 16'h0000 : 16'h0100;
            n_chk++; if (bus0.p0_ack !== e0) begin n_fail++; $display("FAIL rr_p0ack c%0d: got %0b exp %0b", c, bus0.p0_ack, e0); end
            n_chk++; if (bus0.p1_ack !== e1) begin n_fail++; $display("FAIL rr_p1ack c%0d: got %0b exp %0b", c, bus0.p1_ack, e1); end
            n_chk++; if (bus0.m_req !== er) begin n_fail++; $display("FAIL rr_mreq c%0d: got %0b exp %0b", c, bus0.m_req, er); end
            n_chk++; if ((bus0.p0_ack & bus0.p1_ack) !== 1'b0) begin n_fail++; $display("FAIL rr_both_acks c%0d: got 1 exp 0", c); end
            if (er) begin
                n_chk++; if (bus0.m_addr !== ea) begin n_fail++; $display("FAIL rr_maddr c%0d: got %h exp %h", c, bus0.m_addr, ea); end
            end
            if (e0) begin
                n_chk++; if (bus0.p0_rdata !== mem_val(16'h0000)) begin n_fail++; $display("FAIL rr_p0rdata c%0d: got %h exp %h", c, bus0.p0_rdata, mem_val(16'h0000)); end
            end
            if (e1) begin
                n_chk++; if (bus0.p1_rdata !== mem_val(16'h0100)) begin n_fail++; $display("FAIL rr_p1rdata c%0d: got %h exp %h", c, bus0.p1_rdata, mem_val(16'h0100)); end
            end
        end
        tick();
        bus0.p0_req = 1'b0; bus0.p1_req = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority;
        logic e0, e1, er;
        logic [15:0] ea;
        do_reset();
        bus1.p0_req = 1'b1; bus1.p0_addr = 16'h0000;
        bus1.p1_req = 1'b1; bus1.p1_addr = 16'h0100;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            if (c == 9) bus1.p0_req = 1'b0;
            e0 = (c == 2) || (c == 5) || (c == 8);
            e1 = (c == 11);
            er = (c % 3) != 0;
            ea = (c >= 10) ? 16'h0100 : 16'h0000;
            n_chk++; if (bus1.p0_ack !== e0) begin n_fail++; $display("FAIL fp_p0ack c%0d: got %0b exp %0b", c, bus1.p0_ack, e0); end
            n_chk++; if (bus1.p1_ack !== e1) begin n_fail++; $display("FAIL fp_p1ack c%0d: got %0b exp %0b", c, bus1.p1_ack, e1); end
            n_chk++; if (bus1.m_req !== er) begin n_fail++; $display("FAIL fp_mreq c%0d: got %0b exp %0b", c, bus1.m_req, er); end
            if (er) begin
                n_chk++; if (bus1.m_addr !== ea) begin n_fail++; $display("FAIL fp_maddr c%0d: got %h exp %h", c, bus1.m_addr, ea); end
            end
            if (e1) begin
                n_chk++; if (bus1.p1_rdata !== mem_val(16'h0100)) begin n_fail++; $display("FAIL fp_p1rdata c%0d: got %h exp %h", c, bus1.p1_rdata, mem_val(16'h0100)); end
            end
        end
        tick();
        bus1.p1_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] addrs [4];
        logic [15:0] ea;
        logic e0, er;
        addrs[0] = 16'h0010; addrs[1] = 16'h1234; addrs[2] = 16'hFFFF; addrs[3] = 16'h0001;
        do_reset();
        bus0.p0_req = 1'b1; bus0.p0_addr = addrs[0];
        for (int c = 0; c < 13; c++) begin
            if (c > 0) tick();
            if (c == 3 || c == 6 || c == 9) bus0.p0_addr = addrs[c / 3];
            if (c == 12) bus0.p0_req = 1'b0;
            e0 = (c % 3) == 2;
            er = (c % 3) != 0;
            ea = addrs[(c > 11) ? 3 : (c / 3)];
            n_chk++; if (bus0.m_req !== er) begin n_fail++; $display("FAIL b2b_mreq c%0d: got %0b exp %0b", c, bus0.m_req, er); end
            n_chk++; if (bus0.p0_ack !== e0) begin n_fail++; $display("FAIL b2b_ack c%0d: got %0b exp %0b", c, bus0.p0_ack, e0); end
            if (er) begin
                n_chk++; if (bus0.m_addr !== ea) begin n_fail++; $display("FAIL b2b_maddr c%0d: got %h exp %h", c, bus0.m_addr, ea); end
            end
            if (e0) begin
                n_chk++; if (bus0.p0_rdata !== mem_val(ea)) begin n_fail++; $display("FAIL b2b_rdata c%0d: got %h exp %h", c, bus0.p0_rdata, mem_val(ea)); end
            end
        end
        tick();
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0b exp 0", bus0.m_req); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus0.p0_req = 1'b1; bus0.p0_addr = 16'h0040;
        tick();
        n_chk++; if (bus0.m_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %0b exp 1", bus0.m_req); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mreq: got %0b exp 0", bus0.m_req); end
        bus0.p0_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_chk++; if ({bus0.p0_ack, bus0.p1_ack, bus0.m_req} !== 3'b000) begin
                n_fail++; $display("FAIL rstmid_quiet c%0d: got %b exp 000", c, {bus0.p0_ack, bus0.p1_ack, bus0.m_req}); end
        end
        rst = 1'b0;
        bus0.p1_req = 1'b1; bus0.p1_addr = 16'h0100;
        tick();
        n_chk++; if (bus0.m_addr !== 16'h0100) begin n_fail++; $display("FAIL rstmid_p1addr: got %h exp 0100", bus0.m_addr); end
        tick();
        n_chk++; if (bus0.p1_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_p1ack: got %0b exp 1", bus0.p1_ack); end
        n_chk++; if (bus0.p1_rdata !== mem_val(16'h0100)) begin n_fail++; $display("FAIL rstmid_p1rdata: got %h exp %h", bus0.p1_rdata, mem_val(16'h0100)); end
        n_chk++; if (bus0.p0_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_p0ack: got %0b exp 0", bus0.p0_ack); end
        tick();
        bus0.p1_req = 1'b0;
        tick();
    endtask

    task automatic test_dropped_req;
        do_reset();
        bus0.p1_req = 1'b1; bus0.p1_addr = 16'h0200;
        tick();
        bus0.p1_req = 1'b0;
        tick();
        n_chk++; if (bus0.m_ack !== 1'b1) begin n_fail++; $display("FAIL drop_mack: got %0b exp 1", bus0.m_ack); end
        n_chk++; if (bus0.p1_ack !== 1'b0) begin n_fail++; $display("FAIL drop_p1ack: got %0b exp 0", bus0.p1_ack); end
        n_chk++; if (bus0.p0_ack !== 1'b0) begin n_fail++; $display("FAIL drop_p0ack: got %0b exp 0", bus0.p0_ack); end
        tick();
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL drop_gap: got %0b exp 0", bus0.m_req); end
        tick();
        n_chk++; if (bus0.m_req !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %0b exp 0", bus0.m_req); end
        bus0.p0_req = 1'b1; bus0.p0_addr = 16'h0030;
        tick();
        n_chk++; if (bus0.m_addr !== 16'h0030) begin n_fail++; $display("FAIL drop_p0addr: got %h exp 0030", bus0.m_addr); end
        tick();
        n_chk++; if (bus0.p0_ack !== 1'b1) begin n_fail++; $display("FAIL drop_p0ack2: got %0b exp 1", bus0.p0_ack); end
        n_chk++; if (bus0.p0_rdata !== mem_val(16'h0030)) begin n_fail++; $display("FAIL drop_p0rdata: got %h exp %h", bus0.p0_rdata, mem_val(16'h0030)); end
        tick();
        bus0.p0_req = 1'b0;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_rr_contention();
        test_fixed_priority();
        test_back_to_back();
        test_reset_mid();
        test_dropped_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
